// File: rtl/wptr_full_gen_if.sv
// rtl/wptr_full_gen_if.sv - write-client/RAM/read-side bundle for wptr_full_gen (optional wovf/wovf_cnt under WPTR_FULL_GEN_OVF_EN)
interface wptr_full_gen_if #(
    parameter int ADDRSIZE = 4
);
    logic                wpush;
    logic [ADDRSIZE:0]   rptr_wclk;
    logic [ADDRSIZE:0]   afull_thr;
    logic [ADDRSIZE-1:0] waddr;
    logic                wen;
    logic [ADDRSIZE:0]   wptr;
    logic                wfull;
    logic                wafull;
    logic [ADDRSIZE:0]   wcount;
`ifdef WPTR_FULL_GEN_OVF_EN
    logic                wovf;
    logic [7:0]          wovf_cnt;

    modport master (
        output wpush, rptr_wclk, afull_thr,
        input  waddr, wen, wptr, wfull, wafull, wcount, wovf, wovf_cnt
    );
    modport slave (
        input  wpush, rptr_wclk, afull_thr,
        output waddr, wen, wptr, wfull, wafull, wcount, wovf, wovf_cnt
    );
`else
    modport master (
        output wpush, rptr_wclk, afull_thr,
        input  waddr, wen, wptr, wfull, wafull, wcount
    );
    modport slave (
        input  wpush, rptr_wclk, afull_thr,
        output waddr, wen, wptr, wfull, wafull, wcount
    );
`endif
endinterface

// File: rtl/wptr_full_gen.sv
// rtl/wptr_full_gen.sv - async FIFO write pointer, full/almost-full/occupancy generator (optional overflow reporting under WPTR_FULL_GEN_OVF_EN)
module wptr_full_gen #(
    parameter int ADDRSIZE    = 4,
    parameter int SYNC_STAGES = 2
) (
    input logic             wclk,
    input logic             wrst,
    wptr_full_gen_if.slave  bus
);

    logic [ADDRSIZE:0] wbin_q, wbin_d;
    logic [ADDRSIZE:0] wptr_q, wptr_d;
    logic              wfull_q, wfull_d;
    logic              wafull_q, wafull_d;
    logic [ADDRSIZE:0] wcount_q, wcount_d;
    logic [SYNC_STAGES-1:0][ADDRSIZE:0] sync_q, sync_d;

    logic              accept;
    logic [ADDRSIZE:0] rq;
    logic [ADDRSIZE:0] rbin;
    logic [ADDRSIZE:0] full_cmp;

    // Read pointer crossing: a plain shift chain; only the last stage is used
    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = bus.rptr_wclk;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // Gray-to-binary of the synchronised read pointer (prefix XOR from the MSB)
    always_comb begin
        rq   = sync_q[SYNC_STAGES-1];
        rbin = '0;
        for (int i = 0; i <= ADDRSIZE; i++) begin
            rbin[i] = ^(rq >> i);
        end
    end

    // Next pointer and flag values; full compares against the current rq so flags stay pessimistic
    always_comb begin
        accept   = bus.wpush & ~wfull_q;
        wbin_d   = wbin_q + {{ADDRSIZE{1'b0}}, accept};
        wptr_d   = (wbin_d >> 1) ^ wbin_d;
        full_cmp = {~rq[ADDRSIZE:ADDRSIZE-1], rq[ADDRSIZE-2:0]};
        wfull_d  = (wptr_d == full_cmp);
        wcount_d = wbin_d - rbin;
        wafull_d = (wcount_d >= bus.afull_thr);
    end

    // State registers with synchronous reset
    always_ff @(posedge wclk) begin
        if (wrst) begin
            wbin_q   <= '0;
            wptr_q   <= '0;
            wfull_q  <= 1'b0;
            wafull_q <= 1'b0;
            wcount_q <= '0;
            sync_q   <= '0;
        end else begin
            wbin_q   <= wbin_d;
            wptr_q   <= wptr_d;
            wfull_q  <= wfull_d;
            wafull_q <= wafull_d;
            wcount_q <= wcount_d;
            sync_q   <= sync_d;
        end
    end

    assign bus.waddr  = wbin_q[ADDRSIZE-1:0];
    assign bus.wen    = accept;
    assign bus.wptr   = wptr_q;
    assign bus.wfull  = wfull_q;
    assign bus.wafull = wafull_q;
    assign bus.wcount = wcount_q;

`ifdef WPTR_FULL_GEN_OVF_EN
    logic       wovf_q, wovf_d;
    logic [7:0] wovf_cnt_q, wovf_cnt_d;

    // Rejected-push pulse and saturating reject counter
    always_comb begin
        wovf_d     = bus.wpush & wfull_q;
        wovf_cnt_d = wovf_cnt_q;
        if (wovf_d && (wovf_cnt_q != 8'hFF)) begin
            wovf_cnt_d = wovf_cnt_q + 8'd1;
        end
    end

    // Overflow registers with synchronous reset
    always_ff @(posedge wclk) begin
        if (wrst) begin
            wovf_q     <= 1'b0;
            wovf_cnt_q <= '0;
        end else begin
            wovf_q     <= wovf_d;
            wovf_cnt_q <= wovf_cnt_d;
        end
    end

    assign bus.wovf     = wovf_q;
    assign bus.wovf_cnt = wovf_cnt_q;
`endif

endmodule

// File: tb/tb_wptr_full_gen.sv
// tb/tb_wptr_full_gen.sv - randomized self-checking bench for wptr_full_gen against a counting model
module tb_wptr_full_gen;

    localparam int A     = 4;
    localparam int S     = 2;
    localparam int DEPTH = 1 << A;
    localparam int MODV  = 2 * DEPTH;

    logic wclk = 1'b0;
    logic wrst = 1'b1;

    wptr_full_gen_if #(.ADDRSIZE(A)) bus ();

    wptr_full_gen #(.ADDRSIZE(A), .SYNC_STAGES(S)) dut (
        .wclk (wclk),
        .wrst (wrst),
        .bus  (bus)
    );

    always #5 wclk = ~wclk;

    int n_checks = 0;
    int n_errors = 0;

    // model: counts of accepted writes and issued reads, plus a delay line of read counts
    int tot_wr = 0;
    int tot_rd = 0;
    int thr    = 12;
    int m_wr   = 0;
    int hist[S];
    int m_cnt  = 0;
    bit m_full = 0;
    bit m_afull = 0;
    bit m_ovf  = 0;
    int m_ovfc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [A:0] gray(input int v);
        logic [A:0] b;
        b = v[A:0];
        return b ^ (b >> 1);
    endfunction

    task automatic step(input bit push, input bit rst);
        int rseen;
        int occ;
        bit acc;
        @(negedge wclk);
        wrst          = rst;
        bus.wpush     = push;
        bus.rptr_wclk = gray(tot_rd % MODV);
        bus.afull_thr = thr[A:0];
        #1;
        if (!rst) check("wen", {31'd0, bus.wen}, {31'd0, push && !m_full});
        @(posedge wclk);
        if (rst) begin
            tot_wr = 0; m_wr = 0; m_cnt = 0; m_full = 0; m_afull = 0; m_ovf = 0; m_ovfc = 0;
            for (int i = 0; i < S; i++) hist[i] = 0;
        end else begin
            acc    = push && !m_full;
            m_ovf  = push && m_full;
            if (m_ovf && m_ovfc < 255) m_ovfc++;
            tot_wr = tot_wr + int'(acc);
            m_wr   = (m_wr + int'(acc)) % MODV;
            rseen  = hist[S-1];
            for (int i = S - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = tot_rd % MODV;
            occ     = (m_wr - rseen + MODV) % MODV;
            m_cnt   = occ;
            m_full  = (occ == DEPTH);
            m_afull = (occ >= thr);
        end
        #1;
        check("waddr",  {28'd0, bus.waddr},  32'(m_wr % DEPTH));
        check("wptr",   {27'd0, bus.wptr},   {27'd0, gray(m_wr)});
        check("wfull",  {31'd0, bus.wfull},  {31'd0, m_full});
        check("wafull", {31'd0, bus.wafull}, {31'd0, m_afull});
        check("wcount", {27'd0, bus.wcount}, 32'(m_cnt));
`ifdef WPTR_FULL_GEN_OVF_EN
        check("wovf",     {31'd0, bus.wovf},   {31'd0, m_ovf});
        check("wovf_cnt", {24'd0, bus.wovf_cnt}, 32'(m_ovfc));
`endif
    endtask

    initial begin
        int last_addr;
        bit saw_wrap;
        bit saw_full;
        int cyc;
        bit p;
        int thr_tab[6] = '{0, 5, 12, 16, 17, 31};

        bus.wpush     = 1'b0;
        bus.rptr_wclk = '0;
        bus.afull_thr = 5'd12;
        for (int i = 0; i < S; i++) hist[i] = 0;

        // reset with push held and a random read pointer
        tot_rd = $urandom_range(0, MODV - 1);
        step(1, 1);
        step(1, 1);
        tot_rd = 0;
        check("rst_wptr",   {27'd0, bus.wptr},   32'd0);
        check("rst_wcount", {27'd0, bus.wcount}, 32'd0);

        // fill 16, then one ignored push
        for (int i = 0; i < DEPTH; i++) begin
            check("fill_addr_pre", {28'd0, bus.waddr}, 32'(i));
            step(1, 0);
            if (i == 10) check("afull_at_11", {31'd0, bus.wafull}, 32'd0);
            if (i == 11) check("afull_at_12", {31'd0, bus.wafull}, 32'd1);
        end
        check("fill_wptr",   {27'd0, bus.wptr},   32'b11000);
        check("fill_wfull",  {31'd0, bus.wfull},  32'd1);
        check("fill_wcount", {27'd0, bus.wcount}, 32'd16);
        step(1, 0);
        check("ovr_wptr",    {27'd0, bus.wptr},   32'b11000);

        // drain: read pointer jumps to 4, visible after S+1 edges
        tot_rd = 4;
        for (int i = 0; i < S; i++) begin
            step(0, 0);
            check("drain_early_full", {31'd0, bus.wfull}, 32'd1);
        end
        step(0, 0);
        check("drain_full",  {31'd0, bus.wfull},  32'd0);
        check("drain_count", {27'd0, bus.wcount}, 32'd12);

        // wrap: 40 pushes with occupancy kept at or below 8
        tot_rd = 0;
        step(0, 1);
        last_addr = 0; saw_wrap = 0; saw_full = 0; cyc = 0;
        while (tot_wr < 40 && cyc < 400) begin
            if (tot_rd < tot_wr && ($urandom % 2 == 0)) tot_rd++;
            p = (tot_wr - tot_rd < 8) && ($urandom % 4 != 0);
            step(p, 0);
            if (last_addr == DEPTH - 1 && bus.waddr == 0) saw_wrap = 1;
            if (bus.wfull) saw_full = 1;
            last_addr = int'(bus.waddr);
            cyc++;
        end
        check("wrap_done",  32'(tot_wr >= 40), 32'd1);
        check("wrap_seen",  {31'd0, saw_wrap}, 32'd1);
        check("wrap_nofull", {31'd0, saw_full}, 32'd0);

        // random traffic with varying thresholds, including 0 and beyond depth
        tot_rd = 0;
        thr = 0;
        step(0, 1);
        step(0, 0);
        check("thr0_afull", {31'd0, bus.wafull}, 32'd1);
        for (int i = 0; i < 300; i++) begin
            if (i % 50 == 0) thr = thr_tab[$urandom_range(0, 5)];
            if (tot_rd < tot_wr && ($urandom % 3 == 0)) tot_rd++;
            step(($urandom % 4) != 0, 0);
        end

`ifdef WPTR_FULL_GEN_OVF_EN
        // overflow: full FIFO, three rejected pushes
        tot_rd = 0;
        thr = 12;
        step(0, 1);
        for (int i = 0; i < DEPTH; i++) step(1, 0);
        for (int i = 0; i < 3; i++) step(1, 0);
        check("ovf_cnt3",  {24'd0, bus.wovf_cnt}, 32'd3);
        check("ovf_wptr",  {27'd0, bus.wptr},     32'b11000);
        step(0, 0);
        check("ovf_drop",  {31'd0, bus.wovf},     32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wptr_full_gen.md
Name: wptr_full_gen

Overview:
- Parametrised next-generation write-side pointer and flag generator for the async FIFO.
- Produces the write address, the Gray write pointer for the read domain, registered full, almost-full and occupancy outputs.
- Synchronises the incoming read-domain Gray pointer internally.
- Sits in the write clock domain between the write client and the dual-port RAM / read-side pointer block.

Parameters:
- ADDRSIZE, 4, RAM address width; FIFO depth = 2**ADDRSIZE; legal range 2..12.
- SYNC_STAGES, 2, flop stages on rptr_wclk before use; legal range 2..4.

Ports:
- wclk  input  1  write-domain clock.
- wrst  input  1  synchronous active-high reset.
- wpush  input  1  write request.
- rptr_wclk  input  ADDRSIZE+1  read-domain Gray pointer, unsynchronised.
- afull_thr  input  ADDRSIZE+1  almost-full threshold in words; quasi-static.
- waddr  output  ADDRSIZE  RAM write address.
- wen  output  1  RAM write enable = wpush & ~wfull.
- wptr  output  ADDRSIZE+1  registered Gray write pointer.
- wfull  output  1  registered full flag.
- wafull  output  1  registered almost-full flag.
- wcount  output  ADDRSIZE+1  registered occupancy as seen from write domain, 0..2**ADDRSIZE.

Behaviour:
- Reset is synchronous: on a wclk edge with wrst=1, all state clears. This covers wbin, wptr, every sync stage, wfull, wafull and wcount. Reset mid-operation discards all pointer state; no partial push completes.
- Accept rule: push accepted iff wpush=1 and wfull=0 in that cycle. wpush while full is ignored; wbin is unchanged.
- Next binary pointer: n_wbin = wbin + accept, (ADDRSIZE+1)-bit, wraps modulo 2**(ADDRSIZE+1).
- Next Gray pointer: n_wptr = (n_wbin >> 1) ^ n_wbin, zero-extended shift.
- wbin and wptr register n_wbin and n_wptr every cycle.
- waddr = wbin[ADDRSIZE-1:0], combinational from the register. Data for an accepted push is written at the current waddr.
- Sync chain: rptr_wclk passes through SYNC_STAGES flops; the last stage is rq. Nothing else samples rptr_wclk.
- rbin = Gray-to-binary(rq), combinational prefix XOR from the MSB.
- Full: wfull <= (n_wptr == {~rq[ADDRSIZE:ADDRSIZE-1], rq[ADDRSIZE-2:0]}).
  - wfull rises on the same edge that registers the DEPTH-th outstanding push.
- Occupancy: n_count = n_wbin - rbin, modulo 2**(ADDRSIZE+1). wcount <= n_count.
- Almost-full: wafull <= (n_count >= afull_thr).
  - afull_thr=0 holds wafull=1 out of reset +1 cycle.
  - afull_thr > DEPTH never asserts wafull.
- Read progress latency: a change on rptr_wclk affects wfull/wafull/wcount after SYNC_STAGES+1 wclk edges. Flags are pessimistic: they may stay asserted late, never deassert early.
- Wrap-around: pointer MSB toggles every DEPTH pushes. Full/occupancy stay correct across any number of wraps.
- Simultaneous push and read-pointer advance in one cycle: both are applied in n_count; wfull uses the current rq.

Optional Feature:
- Macro: WPTR_FULL_GEN_OVF_EN.
- Defined: adds output wovf (1 bit), registered, reset 0. It pulses 1 for one cycle after each cycle with wpush=1 and wfull=1.
- Defined: adds output wovf_cnt (8 bits), a saturating count of rejected pushes, cleared only by wrst.
- Undefined: neither port exists; rejected pushes are silently dropped.

Test Plan:
- Reset: assert wrst 2 cycles with wpush=1 and random rptr_wclk. Required: waddr=0, wptr=0, wfull=0, wcount=0, wafull=0 (afull_thr=12); wbin does not advance.
- Fill: ADDRSIZE=4, rptr_wclk=0, 16 consecutive pushes. Required: waddr steps 0..15; wptr follows 0,1,3,2,6,...; after 16th edge wptr=5'b11000, wfull=1, wcount=16; 17th push ignored, wptr unchanged.
- Almost-full: afull_thr=12, 12 pushes with no reads. Required: wafull rises on edge of 12th push with wcount=12; wafull=0 at wcount=11.
- Drain: from full, drive rptr_wclk=Gray(4)=5'b00110. Required: wfull=0 and wcount=12 exactly SYNC_STAGES+1 edges later, not earlier.
- Wrap: 40 pushes interleaved with reads keeping occupancy ≤ 8 (rptr_wclk = Gray of read count). Required: wcount matches model every cycle; wfull never set; waddr wraps 15->0.
- Overflow (macro defined): full FIFO, 3 cycles wpush=1. Required: wovf high 3 cycles (one cycle delayed), wovf_cnt=3; state unchanged.
